// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM arbiter: FSM encoding, tag record, default sizing.
package bram_arb_pkg;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_MEM_DELAY = 2;

  // Width needed to index n items, never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Read tag travelling alongside an outstanding BRAM read.
  typedef struct packed {
    logic                valid;
    logic [DEF_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/bram_arb_tagpipe.sv
// Fixed-depth shift register that carries the requester id of each read until its data returns.
module bram_arb_tagpipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_DELAY,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  input  logic [ID_W-1:0] push_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic            any_valid
);

  logic [DEPTH-1:0] vld;
  logic [ID_W-1:0]  ids [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= push_valid;
      for (int k = 1; k < DEPTH; k++) vld[k] <= vld[k-1];
    end
  end

  // NOTE: only the valid bits are reset; an id is never looked at unless its valid is set,
  // so the id storage stays a plain reset-free shift register.
  always_ff @(posedge clk) begin
    ids[0] <= push_id;
    for (int k = 1; k < DEPTH; k++) ids[k] <= ids[k-1];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_id    = ids[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/bram_arbiter.sv
// Fixed-priority burst arbiter in front of a BRAM controller with tagged read-data return.
// Optional debug outputs (dbg_err, dbg_beats) are built when BRAM_ARB_DBG_EN is defined.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DELAY  = DEF_MEM_DELAY,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wren,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DAT_WIDTH-1:0]  req_idat,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DAT_WIDTH-1:0]          rsp_dat,
  output logic [ADDR_WIDTH-1:0]         ctl_addr,
  output logic                          ctl_wren,
  output logic [DAT_WIDTH-1:0]          ctl_idat,
  output logic                          ctl_rden,
  input  logic [DAT_WIDTH-1:0]          ctl_odat,
  input  logic                          ctl_oval,
  output logic                          busy
`ifdef BRAM_ARB_DBG_EN
  ,
  output logic                          dbg_err,
  output logic [NUM_REQ*16-1:0]         dbg_beats
`endif
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = id_width(BURST_LEN);

  state_t           state;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  sel;
  logic [CNT_W-1:0] beat_cnt;
  logic             xfer;
  logic             tag_valid;
  logic [ID_W-1:0]  tag_id;
  logic             tag_any;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) sel = ID_W'(i);
    end
  end

  // Reset gates the datapath so nothing leaks out of a stale GRANT during the reset cycle.
  assign xfer = (state == GRANT) && req_valid[grant] && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant] = 1'b1;
  end

  assign ctl_addr = req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ctl_idat = req_idat[int'(grant)*DAT_WIDTH +: DAT_WIDTH];
  assign ctl_wren = xfer && req_wren[grant];
  assign ctl_rden = xfer && !req_wren[grant];

  // NOTE: registered state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant    <= sel;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!req_valid[grant]) begin
            state <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(BURST_LEN - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bram_arb_tagpipe #(
    .DEPTH (MEM_DELAY),
    .ID_W  (ID_W)
  ) u_tagpipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (ctl_rden),
    .push_id    (grant),
    .out_valid  (tag_valid),
    .out_id     (tag_id),
    .any_valid  (tag_any)
  );

  // Returned data without a matching tag (spurious or dropped by reset) is discarded.
  always_comb begin
    rsp_valid = '0;
    if (ctl_oval && tag_valid && !rst) rsp_valid[tag_id] = 1'b1;
  end

  assign rsp_dat = ctl_odat;
  assign busy    = !rst && ((state == GRANT) || tag_any);

`ifdef BRAM_ARB_DBG_EN
  always_ff @(posedge clk) begin
    if (rst)                       dbg_err <= 1'b0;
    else if (ctl_oval && !tag_valid) dbg_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_beats <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (dbg_beats[i*16 +: 16] != 16'hFFFF))
          dbg_beats[i*16 +: 16] <= dbg_beats[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
